// File: rtl/output_display.sv
// Output stage for the 8-bit CPU: latches the bus on the OUT strobe, converts it to
// sign + three BCD digits with a serial double-dabble, and scans a 4-digit 7-segment display.
module output_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in,
  input  logic        load,
  input  logic        signed_mode,
  output logic [7:0]  value,
  output logic        busy,
  output logic        valid,
  output logic [11:0] digits,
  output logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  value_reg, value_next;
  logic [7:0]  src_reg, src_next;
  logic [11:0] scratch_reg, scratch_next;
  logic [11:0] digits_reg, digits_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        neg_reg, neg_next;
  logic        busy_reg, busy_next;
  logic        valid_reg, valid_next;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]  idx_reg;

  logic [11:0] scratch_adj;
  logic [11:0] scratch_shift;
  logic [7:0]  mag;

  // Add-3 correction on every BCD nibble before each shift
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                      scratch_reg[gi*4 +: 4] + 4'd3 :
                                      scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign scratch_shift = {scratch_adj[10:0], src_reg[7]};
  assign mag = (signed_mode & in[7]) ? (~in + 8'd1) : in;

  always_comb begin
    state_next   = state_reg;
    value_next   = value_reg;
    src_next     = src_reg;
    scratch_next = scratch_reg;
    digits_next  = digits_reg;
    cnt_next     = cnt_reg;
    neg_next     = neg_reg;
    busy_next    = busy_reg;
    valid_next   = valid_reg;
    if (load) begin
      // A new strobe always restarts, even on the would-be completion edge
      value_next   = in;
      neg_next     = signed_mode & in[7];
      scratch_next = 12'd0;
      src_next     = mag;
      cnt_next     = 3'd0;
      valid_next   = 1'b0;
      busy_next    = 1'b1;
      state_next   = CONV;
    end else if (state_reg == CONV) begin
      scratch_next = scratch_shift;
      src_next     = {src_reg[6:0], 1'b0};
      cnt_next     = cnt_reg + 3'd1;
      if (cnt_reg == 3'd7) begin
        digits_next = scratch_shift;
        busy_next   = 1'b0;
        valid_next  = 1'b1;
        state_next  = SHOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      value_reg   <= 8'd0;
      src_reg     <= 8'd0;
      scratch_reg <= 12'd0;
      digits_reg  <= 12'd0;
      cnt_reg     <= 3'd0;
      neg_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      value_reg   <= value_next;
      src_reg     <= src_next;
      scratch_reg <= scratch_next;
      digits_reg  <= digits_next;
      cnt_reg     <= cnt_next;
      neg_reg     <= neg_next;
      busy_reg    <= busy_next;
      valid_reg   <= valid_next;
    end
  end

  // Free-running scan, independent of conversions
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
      idx_reg <= 2'd0;
    end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
      div_reg <= '0;
      idx_reg <= idx_reg + 2'd1;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  always_comb begin
    an  = 4'b0000;
    seg = 7'h00;
    if (valid_reg) begin
      an = 4'b0001 << idx_reg;
      case (idx_reg)
        2'd0: seg = seg_of(digits_reg[3:0]);
        2'd1: seg = (digits_reg[11:4] == 8'd0) ? 7'h00 : seg_of(digits_reg[7:4]);
        2'd2: seg = (digits_reg[11:8] == 4'd0) ? 7'h00 : seg_of(digits_reg[11:8]);
        default: seg = neg_reg ? 7'h40 : 7'h00;
      endcase
    end
  end

  assign value  = value_reg;
  assign busy   = busy_reg;
  assign valid  = valid_reg;
  assign digits = digits_reg;
  assign neg    = neg_reg;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: conversion latency, restart on load, scan content and
// mid-conversion reset, with hand-computed expected digits and segment codes.
module tb_output_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        load = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  value;
  logic        busy, valid, neg;
  logic [11:0] digits;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass = 0;
  logic [11:0] last_digits = 12'd0;

  output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .signed_mode(signed_mode),
    .value(value), .busy(busy), .valid(valid), .digits(digits), .neg(neg),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".value"}, value, 8'h00);
    check({tag, ".digits"}, digits, 12'h000);
    check({tag, ".neg"}, neg, 1'b0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".valid"}, valid, 1'b0);
    check({tag, ".an"}, an, 4'b0000);
    check({tag, ".seg"}, seg, 7'h00);
  endtask

  // Load edge, 7 busy edges, then completion on the 8th edge
  task automatic convert(input logic [7:0] d, input logic sm,
                         input logic [11:0] exp_dig, input logic exp_neg);
    din = d; signed_mode = sm; load = 1'b1;
    step();
    load = 1'b0;
    check("load.value", value, d);
    check("load.neg", neg, exp_neg);
    check("load.busy", busy, 1'b1);
    check("load.valid", valid, 1'b0);
    check("load.digits_hold", digits, last_digits);
    for (int i = 1; i < 8; i++) begin
      step();
      check("conv.busy", busy, 1'b1);
      check("conv.valid", valid, 1'b0);
    end
    step();
    check("done.busy", busy, 1'b0);
    check("done.valid", valid, 1'b1);
    check("done.digits", digits, exp_dig);
    last_digits = exp_dig;
    $display("load in=%02h signed=%0d -> digits=%03h neg=%0d", d, sm, digits, neg);
  endtask

  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_seg [4];
    logic [3:0] prev_an;
    bit found = 0;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int i = 0; i < 8 * SCAN_DIV && !found; i++) begin
      prev_an = an;
      step();
      if (an == 4'b0001 && prev_an == 4'b1000) found = 1;
    end
    check("scan.align", found, 1'b1);
    if (found) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < SCAN_DIV; c++) begin
          check("scan.an", an, 4'b0001 << s);
          check("scan.seg", seg, exp_seg[s]);
          step();
        end
      end
    end
  endtask

  initial begin
    step(); step();
    check_reset_outputs("rst");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_reset_outputs("idle");

    convert(8'hFF, 1'b0, 12'h255, 1'b0);
    check("ff.neg", neg, 1'b0);
    scan_check(7'h6D, 7'h6D, 7'h5B, 7'h00);

    convert(8'h80, 1'b1, 12'h128, 1'b1);
    check("80.value", value, 8'h80);
    scan_check(7'h7F, 7'h5B, 7'h06, 7'h40);

    convert(8'h07, 1'b0, 12'h007, 1'b0);
    scan_check(7'h07, 7'h00, 7'h00, 7'h00);
    convert(8'hFE, 1'b1, 12'h002, 1'b1);
    scan_check(7'h5B, 7'h00, 7'h00, 7'h40);

    // Second load three cycles into a conversion of 0x10
    din = 8'h10; signed_mode = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    check("ovl.value", value, 8'h10);
    for (int i = 0; i < 2; i++) begin
      step();
      check("ovl.valid", valid, 1'b0);
    end
    convert(8'h2A, 1'b0, 12'h042, 1'b0);

    // Second load lands on what would be the completion edge of 0x10
    din = 8'h10; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("late.valid", valid, 1'b0);
    end
    convert(8'h2A, 1'b0, 12'h042, 1'b0);

    // Loads every cycle never let a conversion finish
    load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = 8'(i * 17);
      step();
      check("b2b.busy", busy, 1'b1);
      check("b2b.valid", valid, 1'b0);
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("b2b.done", valid, 1'b1);

    // Reset at iteration 4 of a conversion
    din = 8'hFF; signed_mode = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("midrst.valid", valid, 1'b0);
    end
    check_reset_outputs("midrst.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
